// File: rtl/ahb_rw_scheduler.sv
// ---------------------------------------------------------------------------
// ahb_rw_scheduler
// Sequences the single AHB master port for one edge-detection frame, sharing
// it between pixel fetches (re) and result stores (we). Each transfer is
// granted from buffer occupancy, address-ready flags and a burst-fairness
// limit. Per-frame read/write counts are tracked, frame completion is
// flagged, and a watchdog bounds the time spent waiting on the master.
//
// Ports:
//   clk, n_rst                      clock, asynchronous active-low reset
//   start, abort                    frame start pulse / synchronous abort
//   num_words[31:0]                 words to read and write (latched on start)
//   raddr_ready, waddr_ready        address counter has a valid address
//   in_level, out_level [LVL_W]     input / output buffer occupancy
//   read_complete, write_complete   master completion pulses
//   re, we                          registered read / write requests
//   busy, frame_done, timeout_err   frame status (all registered)
//   rd_count, wr_count [31:0]       transfers completed this frame
// ---------------------------------------------------------------------------
module ahb_rw_scheduler #(
    parameter int LVL_W     = 4,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_HI    = 6,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      num_words,
    input  logic             raddr_ready,
    input  logic             waddr_ready,
    input  logic [LVL_W-1:0] in_level,
    input  logic [LVL_W-1:0] out_level,
    input  logic             read_complete,
    input  logic             write_complete,
    output logic             re,
    output logic             we,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err,
    output logic [31:0]      rd_count,
    output logic [31:0]      wr_count
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int WD_W    = $clog2(TIMEOUT + 1);

    localparam logic [LVL_W-1:0]   IN_DEPTH_L  = LVL_W'(IN_DEPTH);
    localparam logic [LVL_W-1:0]   OUT_HI_L    = LVL_W'(OUT_HI);
    localparam logic [BURST_W-1:0] MAX_BURST_L = BURST_W'(MAX_BURST);
    localparam logic [WD_W-1:0]    WD_LAST_L   = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [31:0]        num_w_r;
    logic [31:0]        rd_count_r;
    logic [31:0]        wr_count_r;
    logic [BURST_W-1:0] burst_r;
    logic [WD_W-1:0]    wd_r;
    logic               re_r;
    logic               we_r;
    logic               busy_r;
    logic               frame_done_r;
    logic               timeout_err_r;

    logic               rd_ok_s;
    logic               wr_ok_s;
    logic               wd_expired_s;
    logic               latch_s;
    logic               rd_inc_s;
    logic               wr_inc_s;
    logic               burst_clr_s;
    logic               burst_inc_s;
    logic               xfer_s;
    logic               xfer_next_s;

    // Transfer eligibility and watchdog expiry from the current registered view.
    always_comb begin
        rd_ok_s      = (rd_count_r < num_w_r) && raddr_ready && (in_level < IN_DEPTH_L);
        wr_ok_s      = (wr_count_r < num_w_r) && waddr_ready && (out_level != {LVL_W{1'b0}});
        wd_expired_s = (wd_r == WD_LAST_L);
        xfer_s       = (state_r == S_READ) || (state_r == S_WRITE);
        xfer_next_s  = (state_s == S_READ) || (state_s == S_WRITE);
    end

    // Next-state and per-cycle update strobes.
    always_comb begin
        state_s     = state_r;
        latch_s     = 1'b0;
        rd_inc_s    = 1'b0;
        wr_inc_s    = 1'b0;
        burst_clr_s = 1'b0;
        burst_inc_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    latch_s = 1'b1;
                    if (num_words == 32'd0) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_ARB;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ARB: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (wr_ok_s && ((out_level >= OUT_HI_L) ||
                                         (burst_r == MAX_BURST_L) || !rd_ok_s)) begin
                    state_s     = S_WRITE;
                    burst_clr_s = 1'b1;
                end else if (rd_ok_s) begin
                    state_s     = S_READ;
                    burst_inc_s = 1'b1;
                end else if ((rd_count_r == num_w_r) && (wr_count_r == num_w_r)) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_ARB;
                end
            end
            S_READ: begin
                // abort wins over a same-cycle completion, which is then dropped
                if (abort) begin
                    state_s = S_IDLE;
                end else if (read_complete) begin
                    rd_inc_s = 1'b1;
                    state_s  = S_ARB;
                end else if (wd_expired_s) begin
                    state_s = S_ERR;
                end else begin
                    state_s = S_READ;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (write_complete) begin
                    wr_inc_s = 1'b1;
                    state_s  = S_ARB;
                end else if (wd_expired_s) begin
                    state_s = S_ERR;
                end else begin
                    state_s = S_WRITE;
                end
            end
            S_DONE:  state_s = S_IDLE;
            S_ERR:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame length latch, completion counters and burst-fairness counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            num_w_r    <= 32'd0;
            rd_count_r <= 32'd0;
            wr_count_r <= 32'd0;
            burst_r    <= {BURST_W{1'b0}};
        end else if (latch_s) begin
            num_w_r    <= num_words;
            rd_count_r <= 32'd0;
            wr_count_r <= 32'd0;
            burst_r    <= {BURST_W{1'b0}};
        end else begin
            if (rd_inc_s) begin
                rd_count_r <= rd_count_r + 32'd1;
            end
            if (wr_inc_s) begin
                wr_count_r <= wr_count_r + 32'd1;
            end
            if (burst_clr_s) begin
                burst_r <= {BURST_W{1'b0}};
            end else if (burst_inc_s && (burst_r != MAX_BURST_L)) begin
                burst_r <= burst_r + BURST_W'(1);
            end
        end
    end

    // Watchdog: zero on entry to READ/WRITE, counts while the transfer stays open.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_r <= {WD_W{1'b0}};
        end else if (xfer_s && xfer_next_s) begin
            wd_r <= wd_r + WD_W'(1);
        end else begin
            wd_r <= {WD_W{1'b0}};
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            re_r          <= 1'b0;
            we_r          <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            re_r         <= (state_s == S_READ);
            we_r         <= (state_s == S_WRITE);
            busy_r       <= (state_s == S_ARB) || xfer_next_s;
            frame_done_r <= (state_s == S_DONE);
            // sticky until the next accepted start
            if (latch_s) begin
                timeout_err_r <= 1'b0;
            end else if (state_s == S_ERR) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign re          = re_r;
    assign we          = we_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign timeout_err = timeout_err_r;
    assign rd_count    = rd_count_r;
    assign wr_count    = wr_count_r;

endmodule
